spi_reg_sequencer: RTL and testbench

Register-access sequencer that sits in front of `SPI_driver` and turns single-register read/write requests into the driver's command/TX/RX FIFO traffic. Two requesters share the SPI link under round-robin arbitration: port 0 is the host endpoint path and port 1 is the sensor init/config engine. One transaction is in flight at a time, and a response goes back to the granted requester.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_reg_sequencer_if.sv | 43 ++++
 rtl/rr_arb2.sv | 42 ++++
 rtl/spi_reg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI register-access sequencer: FSM state
// encoding, SPI_driver command codes, the default write-flag polarity and a
// helper that builds the address byte sent first on MOSI.
// No ports.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_IDLE,
        ST_PUSH_A,
        ST_PUSH_B,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_POP,
        ST_CAPTURE,
        ST_CAPTURE_WAIT,
        ST_RESP
    } seq_state_t;

    // SPI_driver Spi_rw codes
    localparam logic [1:0] SPI_CMD_TX = 2'b01;
    localparam logic [1:0] SPI_CMD_RX = 2'b10;

    localparam logic WR_FLAG_DEFAULT = 1'b1;

    // Address byte: bit 7 carries the access direction, bits 6:0 the register.
    function automatic logic [7:0] addr_byte(input logic       write,
                                             input logic [6:0] addr,
                                             input logic       wr_flag);
        return {(write ? wr_flag : ~wr_flag), addr};
    endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer_if
// Request/response bundle between the two requesters (port 0 = host endpoint,
// port 1 = sensor init engine) and the sequencer.
//   reqN_valid/write/addr/wdata : requester -> sequencer
//   reqN_ready                  : sequencer -> requester, accept pulse
//   rsp_valid/id/rdata/err      : sequencer -> requesters, one-cycle response
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface spi_reg_sequencer_if;

    logic       req0_valid;
    logic       req0_ready;
    logic       req0_write;
    logic [6:0] req0_addr;
    logic [7:0] req0_wdata;

    logic       req1_valid;
    logic       req1_ready;
    logic       req1_write;
    logic [6:0] req1_addr;
    logic [7:0] req1_wdata;

    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. On a tie the port that was not served last
// wins; the history pointer resets to 1 so port 0 wins the first tie.
//   clk, rst  : clock, synchronous active-high reset
//   i_req     : request vector {port1, port0}
//   i_update  : load i_id into the history pointer (transaction finished)
//   i_id      : id of the requester just served
//   o_grant   : one-hot grant, combinational from i_req and history
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_id,
    output logic [1:0] o_grant
);

    logic r_last_id;

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id <= 1'b1;
        end else if (i_update) begin
            r_last_id <= i_id;
        end
    end

    // NOTE: o_grant gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_id ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer
// Turns single-register read/write requests from two requesters into
// SPI_driver command/TX/RX FIFO traffic, one transaction at a time.
//   clk, rst     : clock shared with SPI_driver, synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   spi_cmd_push : -> driver command_read
//   spi_cmd      : -> driver Spi_rw (01 TX byte, 10 RX byte)
//   spi_tx_push  : -> driver tx_read
//   spi_tx_data  : -> driver Spi_tx_reg
//   spi_rx_pop   : -> driver rx_read
//   spi_rx_data  : <- driver Spi_rx_reg
//   spi_busy     : <- driver busy
// -----------------------------------------------------------------------------
module spi_reg_sequencer
    import spi_pkg::*;
#(
    parameter logic        WR_FLAG       = WR_FLAG_DEFAULT,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_sequencer_if.slave   bus,
    output logic                 spi_cmd_push,
    output logic [1:0]           spi_cmd,
    output logic                 spi_tx_push,
    output logic [7:0]           spi_tx_data,
    output logic                 spi_rx_pop,
    input  logic [7:0]           spi_rx_data,
    input  logic                 spi_busy
);

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             r_write;
    logic [6:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_id;
    logic             r_err;
    logic [7:0]       r_rdata;
    logic [TMR_W-1:0] r_timer;
    logic             r_idle_seen;   // busy was low on the previous cycle

    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_timeout;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({bus.req1_valid, bus.req0_valid}),
        .i_update (r_state == ST_RESP),
        .i_id     (r_id),
        .o_grant  (w_grant)
    );

    assign w_accept  = (r_state == ST_IDLE) && (w_grant != 2'b00);
    // Last WAIT_START cycle of the window: busy did not rise in time.
    assign w_timeout = (r_timer == TMR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SYNC;
            r_idle_seen <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idle_seen <= ~spi_busy;

            if (w_accept) begin
                r_id    <= w_grant[1];
                r_write <= w_grant[1] ? bus.req1_write : bus.req0_write;
                r_addr  <= w_grant[1] ? bus.req1_addr  : bus.req0_addr;
                r_wdata <= w_grant[1] ? bus.req1_wdata : bus.req0_wdata;
                r_err   <= 1'b0;
                r_rdata <= '0;    // stays 0 for writes and timed-out reads
            end

            if (r_state == ST_PUSH_B) begin
                r_timer <= TMR_W'(START_TIMEOUT);
            end else if (r_state == ST_WAIT_START) begin
                r_timer <= r_timer - 1'b1;
            end

            if (r_state == ST_WAIT_START && !spi_busy && w_timeout) begin
                r_err <= 1'b1;
            end

            // Spi_rx_reg updated on the edge after the pop; sample one cycle later.
            if (r_state == ST_CAPTURE_WAIT) begin
                r_rdata <= spi_rx_data;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_id     = 1'b0;
        bus.rsp_rdata  = '0;
        bus.rsp_err    = 1'b0;
        spi_cmd_push   = 1'b0;
        spi_cmd        = 2'b00;
        spi_tx_push    = 1'b0;
        spi_tx_data    = '0;
        spi_rx_pop     = 1'b0;

        case (r_state)
            ST_SYNC: begin
                if (!spi_busy && r_idle_seen) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    bus.req0_ready = w_grant[0];
                    bus.req1_ready = w_grant[1];
                    w_state_next   = ST_PUSH_A;
                end
            end
            ST_PUSH_A: begin
                spi_cmd_push = 1'b1;
                spi_cmd      = SPI_CMD_TX;
                spi_tx_push  = 1'b1;
                spi_tx_data  = addr_byte(r_write, r_addr, WR_FLAG);
                w_state_next = ST_PUSH_B;
            end
            ST_PUSH_B: begin
                // Back-to-back with PUSH_A so the driver keeps SPI_EN asserted.
                spi_cmd_push = 1'b1;
                if (r_write) begin
                    spi_cmd     = SPI_CMD_TX;
                    spi_tx_push = 1'b1;
                    spi_tx_data = r_wdata;
                end else begin
                    spi_cmd     = SPI_CMD_RX;
                end
                w_state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (spi_busy)       w_state_next = ST_WAIT_DONE;
                else if (w_timeout) w_state_next = ST_RESP;
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) w_state_next = r_write ? ST_RESP : ST_POP;
            end
            ST_POP: begin
                spi_rx_pop   = 1'b1;
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE:      w_state_next = ST_CAPTURE_WAIT;
            ST_CAPTURE_WAIT: w_state_next = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = r_id;
                bus.rsp_rdata = r_rdata;
                bus.rsp_err   = r_err;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_SYNC;
        endcase
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_sequencer
// Scoreboard bench for spi_reg_sequencer with a behavioural SPI_driver model
// (busy pulse after a command pair, RX register loaded on pop, FF when empty).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_reg_sequencer;

    localparam int START_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    spi_reg_sequencer_if bus();

    logic       spi_cmd_push;
    logic [1:0] spi_cmd;
    logic       spi_tx_push;
    logic [7:0] spi_tx_data;
    logic       spi_rx_pop;
    logic [7:0] spi_rx_data = 8'hEE;
    logic       spi_busy    = 1'b0;

    spi_reg_sequencer #(
        .WR_FLAG       (1'b1),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .spi_cmd_push (spi_cmd_push),
        .spi_cmd      (spi_cmd),
        .spi_tx_push  (spi_tx_push),
        .spi_tx_data  (spi_tx_data),
        .spi_rx_pop   (spi_rx_pop),
        .spi_rx_data  (spi_rx_data),
        .spi_busy     (spi_busy)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // ---------------- SPI_driver model ----------------
    bit         drv_no_busy  = 1'b0;
    int         drv_busy_len = 20;
    logic [7:0] miso_q[$];
    int         cmd_seen  = 0;
    int         start_cnt = -1;
    int         busy_cnt  = 0;

    initial forever begin
        @(posedge clk);
        if (spi_cmd_push) begin
            if (cmd_seen == 1) begin
                cmd_seen  <= 0;
                start_cnt <= drv_no_busy ? -1 : 2;
            end else begin
                cmd_seen <= cmd_seen + 1;
            end
        end
        if (start_cnt > 0) begin
            start_cnt <= start_cnt - 1;
        end else if (start_cnt == 0) begin
            start_cnt <= -1;
            spi_busy  <= 1'b1;
            busy_cnt  <= drv_busy_len;
        end
        if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            spi_busy <= 1'b0;
        end
        if (spi_rx_pop) begin
            if (miso_q.size() != 0) spi_rx_data <= miso_q.pop_front();
            else                    spi_rx_data <= 8'hFF;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       id;
        logic [7:0] rdata;
        logic       err;
        logic [7:0] lat;     // grant-to-response cycles, 0 = not checked
    } rsp_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic       tx_push;
        logic [7:0] tx_data;
        logic       second;
    } push_t;

    rsp_t  rsp_q[$];
    push_t push_q[$];
    logic  grant_q[$];

    int grant_cyc     = 0;
    int last_push_cyc = 0;
    int fall_cyc      = 0;
    int acc_cyc       = 0;

    task automatic expect_txn(input logic id, input logic [7:0] a_byte, input logic wr,
                              input logic [7:0] wdata, input bit want_rsp,
                              input logic [7:0] rdata, input logic err, input logic [7:0] lat);
        grant_q.push_back(id);
        push_q.push_back('{cmd: 2'b01, tx_push: 1'b1, tx_data: a_byte, second: 1'b0});
        if (wr) push_q.push_back('{cmd: 2'b01, tx_push: 1'b1, tx_data: wdata, second: 1'b1});
        else    push_q.push_back('{cmd: 2'b10, tx_push: 1'b0, tx_data: 8'h00, second: 1'b1});
        if (want_rsp) rsp_q.push_back('{id: id, rdata: rdata, err: err, lat: lat});
    endtask

    // grant monitor
    initial forever begin
        logic g;
        @(negedge clk);
        #2;
        if (!rst && (bus.req0_ready || bus.req1_ready)) begin
            check("single_ready", 32'($countones({bus.req1_ready, bus.req0_ready})), 1);
            check("grant_expected", 32'(grant_q.size() != 0), 1);
            if (grant_q.size() != 0) begin
                g = grant_q.pop_front();
                check("grant_id", 32'(bus.req1_ready), 32'(g));
            end
            grant_cyc = cyc;
        end
    end

    // push monitor
    initial forever begin
        push_t p;
        @(negedge clk);
        #2;
        if (!rst && (spi_cmd_push || spi_tx_push)) begin
            check("push_expected", 32'(push_q.size() != 0), 1);
            if (push_q.size() != 0) begin
                p = push_q.pop_front();
                check("push_cmd", 32'({spi_cmd_push, spi_cmd}), 32'({1'b1, p.cmd}));
                check("push_tx", 32'({spi_tx_push, spi_tx_data}), 32'({p.tx_push, p.tx_data}));
                if (p.second) check("push_gap", 32'(cyc - last_push_cyc), 1);
            end
            last_push_cyc = cyc;
        end
    end

    // response monitor
    initial forever begin
        rsp_t r;
        @(negedge clk);
        #2;
        if (!rst && bus.rsp_valid) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(r.id));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
                check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
                if (r.lat != 8'd0) check("rsp_latency", 32'(cyc - grant_cyc), 32'(r.lat));
            end
        end
    end

    // busy falling-edge tracker
    initial forever begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_busy && !spi_busy) fall_cyc = cyc;
            prev_busy = spi_busy;
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic drive_req(input bit port, input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        bit got;
        got = 1'b0;
        if (port == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
        end
        for (int i = 0; i < 500 && !got; i++) begin
            #1;
            if (!rst && (port ? bus.req1_ready : bus.req0_ready)) begin
                got     = 1'b1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        check($sformatf("accept_port%0d", port), 32'(got), 1);
    endtask

    task automatic release_req(input bit port);
        if (port == 1'b0) bus.req0_valid = 1'b0;
        else              bus.req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int left;
        left = 1;
        for (int i = 0; i < 2000 && left != 0; i++) begin
            @(negedge clk);
            left = rsp_q.size() + push_q.size() + grant_q.size();
        end
        repeat (2) @(negedge clk);
        check("drain", 32'(left), 0);
    endtask

    initial begin
        int rel_cyc;
        bit busy_seen;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs",
              32'({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_rdata,
                   bus.rsp_err, spi_cmd_push, spi_cmd, spi_tx_push, spi_tx_data, spi_rx_pop}), 0);
        @(negedge clk);

        // Port 0 write 0x3A <= 0x5C, request waiting as reset releases.
        expect_txn(1'b0, 8'hBA, 1'b1, 8'h5C, 1'b1, 8'h00, 1'b0, 8'd0);
        rst     = 1'b0;
        rel_cyc = cyc;
        drive_req(1'b0, 1'b1, 7'h3A, 8'h5C);
        release_req(1'b0);
        check("sync_len", 32'(acc_cyc - rel_cyc), 2);
        wait_drain();

        // Port 1 read 0x12, MISO 0xA7.
        miso_q.push_back(8'hA7);
        expect_txn(1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 8'hA7, 1'b0, 8'd0);
        drive_req(1'b1, 1'b0, 7'h12, 8'h00);
        release_req(1'b1);
        wait_drain();

        // Both ports valid continuously, last served = 1: grants 0,1,0,1.
        miso_q.push_back(8'h4B);
        miso_q.push_back(8'hC3);
        expect_txn(1'b0, 8'h81, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 8'd0);
        expect_txn(1'b1, 8'h83, 1'b1, 8'h30, 1'b1, 8'h00, 1'b0, 8'd0);
        expect_txn(1'b0, 8'h02, 1'b0, 8'h00, 1'b1, 8'h4B, 1'b0, 8'd0);
        expect_txn(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 8'd0);
        fork
            begin
                drive_req(1'b0, 1'b1, 7'h01, 8'h10);
                drive_req(1'b0, 1'b0, 7'h02, 8'h00);
                release_req(1'b0);
            end
            begin
                drive_req(1'b1, 1'b1, 7'h03, 8'h30);
                drive_req(1'b1, 1'b0, 7'h04, 8'h00);
                release_req(1'b1);
            end
        join
        wait_drain();

        // Port 0 read 0x7F with empty driver RX FIFO: FF passes through.
        expect_txn(1'b0, 8'h7F, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'd0);
        drive_req(1'b0, 1'b0, 7'h7F, 8'h00);
        release_req(1'b0);
        wait_drain();

        // Last served = 0, both valid: port 1 first, then port 0.
        expect_txn(1'b1, 8'hAB, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'd0);
        expect_txn(1'b0, 8'hD5, 1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 8'd0);
        fork
            begin drive_req(1'b0, 1'b1, 7'h55, 8'hAA); release_req(1'b0); end
            begin drive_req(1'b1, 1'b1, 7'h2B, 8'h01); release_req(1'b1); end
        join
        wait_drain();

        // Busy never rises: timeout after 16 WAIT_START cycles, err=1, rdata=0.
        drv_no_busy = 1'b1;
        miso_q.push_back(8'h5A);
        expect_txn(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'd19);
        drive_req(1'b1, 1'b0, 7'h10, 8'h00);
        release_req(1'b1);
        wait_drain();
        expect_txn(1'b0, 8'hA0, 1'b1, 8'h99, 1'b1, 8'h00, 1'b1, 8'd19);
        drive_req(1'b0, 1'b1, 7'h20, 8'h99);
        release_req(1'b0);
        wait_drain();
        check("no_pop_on_timeout", 32'(miso_q.size()), 1);
        miso_q.delete();
        drv_no_busy = 1'b0;

        // Reset during WAIT_DONE of a read: no response, SYNC waits for busy to drain.
        drv_busy_len = 40;
        expect_txn(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0);
        drive_req(1'b1, 1'b0, 7'h33, 8'h00);
        release_req(1'b1);
        busy_seen = 1'b0;
        for (int i = 0; i < 100 && !busy_seen; i++) begin
            @(negedge clk);
            busy_seen = spi_busy;
        end
        check("busy_seen", 32'(busy_seen), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drv_busy_len = 20;
        miso_q.push_back(8'h6D);
        expect_txn(1'b0, 8'h21, 1'b0, 8'h00, 1'b1, 8'h6D, 1'b0, 8'd0);
        drive_req(1'b0, 1'b0, 7'h21, 8'h00);
        release_req(1'b0);
        check("sync_after_busy", 32'(acc_cyc - fall_cyc), 2);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
